// File: rtl/gpsdc_pkg.sv
// Shared types and constants for the gpsdc_track great-circle distance engine.
package gpsdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COS_SCAN,
        ST_COS_DONE,
        ST_ASIN_SCAN,
        ST_OUT
    } state_t;

    localparam logic [15:0] K_RAD_DEF   = 16'h477;
    localparam logic [23:0] R_EARTH_DEF = 24'd12756274;
    localparam int          RE_W        = 24;
    // Cosine query is the latitude with 16 zero fraction bits appended.
    localparam int          QX_PAD_W    = 16;
    localparam int          ACC_GUARD_W = 8;

endpackage

// File: rtl/gpsdc_track_if.sv
// Fix-in / result-out bundle for gpsdc_track; total_d exists only with GPSDC_TRACK_ACCUM_EN.
interface gpsdc_track_if #(
    parameter int COORD_W = 24,
    parameter int A_W     = 64,
    parameter int D_W     = 40
) ();
    import gpsdc_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] lat_in;
    logic [COORD_W-1:0] lon_in;
    logic               out_valid;
    logic [A_W-1:0]     a_out;
    logic [D_W-1:0]     d_out;
    logic               out_sat;
`ifdef GPSDC_TRACK_ACCUM_EN
    logic [D_W+ACC_GUARD_W-1:0] total_d;

    modport master (output in_valid, lat_in, lon_in,
                    input  in_ready, out_valid, a_out, d_out, out_sat, total_d);
    modport slave  (input  in_valid, lat_in, lon_in,
                    output in_ready, out_valid, a_out, d_out, out_sat, total_d);
`else
    modport master (output in_valid, lat_in, lon_in,
                    input  in_ready, out_valid, a_out, d_out, out_sat);
    modport slave  (input  in_valid, lat_in, lon_in,
                    output in_ready, out_valid, a_out, d_out, out_sat);
`endif

endinterface

// File: rtl/gpsdc_lut_interp.sv
// Linear-scan lookup over a combinational {x,y} ROM with linear interpolation
// between the last entry not above the query and the first entry above it.
module gpsdc_lut_interp #(
    parameter int AW = 7,
    parameter int XW = 40,
    parameter int YW = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic          start,
    input  logic          run,
    input  logic [XW-1:0] qx,
    input  logic [XW+YW-1:0] entry,
    output logic [AW-1:0] addr,
    output logic          done,
    output logic [YW-1:0] y,
    output logic          sat
);
    localparam int NUM_W = XW + YW + 2;

    logic [XW-1:0] ent_x, prev_x;
    logic [YW-1:0] ent_y, prev_y, y_now;
    logic          have_prev, hit, last;

    assign ent_x = entry[XW+YW-1:YW];
    assign ent_y = entry[YW-1:0];
    assign hit   = ent_x > qx;
    assign last  = (addr == {AW{1'b1}});
    assign done  = run && (hit || last);

    // Exact signed numerator; x0 <= qx < x1 keeps the quotient inside [y0,y1].
    function automatic logic [YW-1:0] interp(input logic [XW-1:0] x0, x1, xq,
                                             input logic [YW-1:0] y0, y1);
        logic signed [NUM_W-1:0] y0_s, y1_s, dx_s, qd_s, num_s, quo_s;
        y0_s  = NUM_W'(y0);
        y1_s  = NUM_W'(y1);
        dx_s  = NUM_W'(x1 - x0);
        qd_s  = NUM_W'(xq - x0);
        num_s = y0_s * dx_s + qd_s * (y1_s - y0_s);
        quo_s = num_s / dx_s;
        return quo_s[YW-1:0];
    endfunction

    always_comb begin
        y_now = ent_y;
        if (hit && have_prev)
            y_now = interp(prev_x, ent_x, qx, prev_y, ent_y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            have_prev <= 1'b0;
            sat       <= 1'b0;
        end else if (abort || start) begin
            addr      <= '0;
            have_prev <= 1'b0;
        end else if (run) begin
            if (done) begin
                sat <= !hit;
            end else begin
                have_prev <= 1'b1;
                addr      <= addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run && !abort) begin
            if (done) begin
                y <= y_now;
            end else begin
                prev_x <= ent_x;
                prev_y <= ent_y;
            end
        end
    end

endmodule

// File: rtl/gpsdc_track.sv
// Haversine distance between consecutive GPS fixes via scanned cosine/arcsine ROMs.
// Define GPSDC_TRACK_ACCUM_EN to add the saturating total_d accumulator.
module gpsdc_track
    import gpsdc_pkg::*;
#(
    parameter int          COORD_W = 24,
    parameter int          COS_AW  = 7,
    parameter int          COS_YW  = 48,
    parameter int          ASIN_AW = 6,
    parameter int          A_W     = 64,
    parameter int          ASIN_YW = 64,
    parameter logic [15:0] K_RAD   = K_RAD_DEF,
    parameter logic [23:0] R_EARTH = R_EARTH_DEF,
    parameter int          D_SHIFT = 32,
    parameter int          D_W     = 40
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    gpsdc_track_if.slave                    bus,
    output logic [COS_AW-1:0]               cos_addr,
    input  logic [COORD_W+QX_PAD_W+COS_YW-1:0] cos_data,
    output logic [ASIN_AW-1:0]              asin_addr,
    input  logic [A_W+ASIN_YW-1:0]          asin_data
);
    localparam int COS_XW = COORD_W + QX_PAD_W;
    localparam int S_W    = COORD_W + 16;
    localparam int T_W    = 2*COS_YW + 2*S_W + 1;
    localparam int DP_W   = RE_W + ASIN_YW;
`ifdef GPSDC_TRACK_ACCUM_EN
    localparam int TOT_W  = D_W + ACC_GUARD_W;
    localparam int TOT_W1 = TOT_W + 1;
`endif

    state_t             state;
    logic               have_fix, accept, asin_start;
    logic               cos_done, asin_done, cos_sat, asin_sat;
    logic [COORD_W-1:0] lat_p0, lon_p0, lat_p1, lon_p1;
    logic [COS_XW-1:0]  cos_qx;
    logic [COS_YW-1:0]  cos_y, c_p1;
    logic [A_W-1:0]     a_p1;
    logic [ASIN_YW-1:0] asin_y;
    logic [D_W-1:0]     d_next;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] p, q);
        return (p > q) ? (p - q) : (q - p);
    endfunction

    function automatic logic [S_W-1:0] half_scale(input logic [COORD_W-1:0] d);
        return S_W'((S_W'(d) * S_W'(K_RAD)) >> 1);
    endfunction

    // Full-width sum before the single final shift; nothing truncated earlier.
    function automatic logic [A_W-1:0] calc_a(input logic [COORD_W-1:0] la0, la1, lo0, lo1,
                                              input logic [COS_YW-1:0]  c0, c1);
        logic [S_W-1:0] s_lat, s_lon;
        logic [T_W-1:0] t_lat, t_lon;
        s_lat = half_scale(abs_diff(la0, la1));
        s_lon = half_scale(abs_diff(lo0, lo1));
        t_lat = (T_W'(s_lat) * T_W'(s_lat)) << (2*COS_YW);
        t_lon = T_W'(c0) * T_W'(c1) * T_W'(s_lon) * T_W'(s_lon);
        return A_W'((t_lat + t_lon) >> (2*COS_YW));
    endfunction

    function automatic logic [D_W-1:0] calc_d(input logic [ASIN_YW-1:0] yv);
        return D_W'((DP_W'(R_EARTH) * DP_W'(yv)) >> D_SHIFT);
    endfunction

`ifdef GPSDC_TRACK_ACCUM_EN
    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] acc,
                                                 input logic [D_W-1:0]   inc);
        logic [TOT_W:0] sum;
        sum = {1'b0, acc} + TOT_W1'(inc);
        return sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
    endfunction
`endif

    assign bus.in_ready = (state == ST_IDLE) && !clear;
    assign accept       = (state == ST_IDLE) && bus.in_valid && !clear;
    assign asin_start   = (state == ST_COS_DONE) && have_fix;
    assign cos_qx       = {lat_p0, {QX_PAD_W{1'b0}}};
    assign d_next       = calc_d(asin_y);

    gpsdc_lut_interp #(.AW(COS_AW), .XW(COS_XW), .YW(COS_YW)) u_cos (
        .clk   (clk),
        .rst_n (reset_n),
        .abort (clear),
        .start (accept),
        .run   (state == ST_COS_SCAN),
        .qx    (cos_qx),
        .entry (cos_data),
        .addr  (cos_addr),
        .done  (cos_done),
        .y     (cos_y),
        .sat   (cos_sat)
    );

    gpsdc_lut_interp #(.AW(ASIN_AW), .XW(A_W), .YW(ASIN_YW)) u_asin (
        .clk   (clk),
        .rst_n (reset_n),
        .abort (clear),
        .start (asin_start),
        .run   (state == ST_ASIN_SCAN),
        .qx    (a_p1),
        .entry (asin_data),
        .addr  (asin_addr),
        .done  (asin_done),
        .y     (asin_y),
        .sat   (asin_sat)
    );

    // Control path and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            have_fix      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.a_out     <= '0;
            bus.d_out     <= '0;
            bus.out_sat   <= 1'b0;
`ifdef GPSDC_TRACK_ACCUM_EN
            bus.total_d   <= '0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            if (clear) begin
                state    <= ST_IDLE;
                have_fix <= 1'b0;
`ifdef GPSDC_TRACK_ACCUM_EN
                bus.total_d <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE:      if (bus.in_valid) state <= ST_COS_SCAN;
                    ST_COS_SCAN:  if (cos_done) state <= ST_COS_DONE;
                    ST_COS_DONE: begin
                        if (have_fix) begin
                            state <= ST_ASIN_SCAN;
                        end else begin
                            have_fix <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_ASIN_SCAN: if (asin_done) state <= ST_OUT;
                    ST_OUT: begin
                        bus.out_valid <= 1'b1;
                        bus.a_out     <= a_p1;
                        bus.d_out     <= d_next;
                        bus.out_sat   <= cos_sat | asin_sat;
`ifdef GPSDC_TRACK_ACCUM_EN
                        bus.total_d   <= sat_add(bus.total_d, d_next);
`endif
                        state         <= ST_IDLE;
                    end
                    default:      state <= ST_IDLE;
                endcase
            end
        end
    end

    // Fix slots (_p0 new, _p1 previous) and the haversine term
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_p0 <= bus.lat_in;
            lon_p0 <= bus.lon_in;
        end
        if ((state == ST_COS_DONE && !have_fix) || state == ST_OUT) begin
            lat_p1 <= lat_p0;
            lon_p1 <= lon_p0;
            c_p1   <= cos_y;
        end
        if (state == ST_COS_DONE)
            a_p1 <= calc_a(lat_p1, lat_p0, lon_p1, lon_p0, c_p1, cos_y);
    end

endmodule

// File: tb/tb_gpsdc_track.sv
// Directed bench for gpsdc_track with small behavioural cosine/arcsine ROMs.
module tb_gpsdc_track;
    localparam int COORD_W = 24;
    localparam int COS_AW  = 7;
    localparam int COS_YW  = 48;
    localparam int ASIN_AW = 6;
    localparam int A_W     = 64;
    localparam int ASIN_YW = 64;
    localparam int D_W     = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic [COS_AW-1:0]           cos_addr;
    logic [COORD_W+16+COS_YW-1:0] cos_data;
    logic [ASIN_AW-1:0]          asin_addr;
    logic [A_W+ASIN_YW-1:0]      asin_data;
    int asin_mode = 0;
    int n_cmp = 0;
    int n_bad = 0;

    gpsdc_track_if #(.COORD_W(COORD_W), .A_W(A_W), .D_W(D_W)) bus ();

    gpsdc_track #(
        .COORD_W(COORD_W), .COS_AW(COS_AW), .COS_YW(COS_YW), .ASIN_AW(ASIN_AW),
        .A_W(A_W), .ASIN_YW(ASIN_YW), .D_W(D_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .bus       (bus),
        .cos_addr  (cos_addr),
        .cos_data  (cos_data),
        .asin_addr (asin_addr),
        .asin_data (asin_data)
    );

    always #5 clk = ~clk;

    // Cosine: e0={0,2^47}, e1={0x200000,2^46}, then rising x.
    function automatic logic [87:0] cos_rom(input logic [6:0] a);
        logic [39:0] x;
        logic [47:0] y;
        if (a == 7'd0) begin
            x = 40'd0;
            y = 48'h1 << 47;
        end else begin
            x = 40'(a) * 40'h200000;
            y = 48'h1 << 46;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] asin_rom(input logic [5:0] a, input int mode);
        logic [63:0] x, y;
        case (mode)
            0: begin x = 64'(a) * 64'd65536; y = x; end
            1: begin x = 64'(a) * 64'd100;   y = x; end
            default: begin
                x = 64'd0;
                y = (a == 6'd63) ? (64'h1 << 40) : 64'd5;
            end
        endcase
        return {x, y};
    endfunction

    assign cos_data  = cos_rom(cos_addr);
    assign asin_data = asin_rom(asin_addr, asin_mode);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_fix(input logic [23:0] lat, input logic [23:0] lon);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_before_send: got %0b expected 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.lat_in   = lat;
        bus.lon_in   = lon;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int lat_cyc);
        lat_cyc = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat_cyc = n;
                break;
            end
        end
    endtask

    task automatic watch_quiet(input int cycles, output int hits);
        hits = 0;
        for (int n = 0; n < cycles; n++) begin
            tick();
            if (bus.out_valid !== 1'b0) hits++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.lat_in   = '0;
        bus.lon_in   = '0;
        reset_n      = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.out_sat} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 100", {bus.in_ready, bus.out_valid, bus.out_sat});
        end
        n_cmp++;
        if (bus.a_out !== 64'd0 || bus.d_out !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_data: got a=%0d d=%0d expected 0 0", bus.a_out, bus.d_out);
        end
        n_cmp++;
        if (cos_addr !== 7'd0 || asin_addr !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_addr: got %0d/%0d expected 0/0", cos_addr, asin_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_first_fix();
        int hits;
        asin_mode = 0;
        send_fix(24'h10, 24'h1000);
        tick();
        n_cmp++;
        if (cos_addr !== 7'd1) begin
            n_bad++;
            $display("FAIL first_cos_addr: got %0d expected 1", cos_addr);
        end
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL first_busy: got %0b expected 0", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL first_idle_3cyc: got %0b expected 1", bus.in_ready);
        end
        watch_quiet(8, hits);
        n_cmp++;
        if (hits !== 0) begin
            n_bad++;
            $display("FAIL first_no_out: got %0d strobes expected 0", hits);
        end
    endtask

    task automatic test_second_fix();
        int lat_cyc;
        asin_mode = 0;
        send_fix(24'h10, 24'h1001);
        wait_out(30, lat_cyc);
        n_cmp++;
        if (lat_cyc !== 6) begin
            n_bad++;
            $display("FAIL second_latency: got %0d expected 6", lat_cyc);
        end
        n_cmp++;
        if (bus.a_out !== 64'd45849) begin
            n_bad++;
            $display("FAIL second_a: got %0d expected 45849", bus.a_out);
        end
        n_cmp++;
        if (bus.d_out !== 40'd136 || bus.out_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL second_d_sat: got d=%0d sat=%0b expected 136 0", bus.d_out, bus.out_sat);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL second_strobe_len: got %0b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_identical();
        int lat_cyc;
        asin_mode = 1;
        send_fix(24'h10, 24'h1001);
        wait_out(30, lat_cyc);
        n_cmp++;
        if (lat_cyc !== 6) begin
            n_bad++;
            $display("FAIL ident_latency: got %0d expected 6", lat_cyc);
        end
        n_cmp++;
        if (bus.a_out !== 64'd0 || bus.d_out !== 40'd0 || bus.out_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL ident_result: got a=%0d d=%0d sat=%0b expected 0 0 0",
                     bus.a_out, bus.d_out, bus.out_sat);
        end
    endtask

    task automatic test_saturate();
        int lat_cyc;
        asin_mode = 2;
        send_fix(24'h10, 24'h1002);
        wait_out(120, lat_cyc);
        n_cmp++;
        if (lat_cyc !== 68) begin
            n_bad++;
            $display("FAIL sat_latency: got %0d expected 68", lat_cyc);
        end
        n_cmp++;
        if (bus.out_sat !== 1'b1 || bus.d_out !== 40'd3265606144) begin
            n_bad++;
            $display("FAIL sat_result: got sat=%0b d=%0d expected 1 3265606144", bus.out_sat, bus.d_out);
        end
        n_cmp++;
        if (bus.a_out !== 64'd45849) begin
            n_bad++;
            $display("FAIL sat_a: got %0d expected 45849", bus.a_out);
        end
        repeat (3) tick();
        n_cmp++;
        if (bus.d_out !== 40'd3265606144 || bus.out_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_hold: got d=%0d sat=%0b expected 3265606144 1", bus.d_out, bus.out_sat);
        end
    endtask

    task automatic test_reset_mid_scan();
        asin_mode = 0;
        send_fix(24'h10, 24'h1003);
        tick();
        n_cmp++;
        if (cos_addr !== 7'd1) begin
            n_bad++;
            $display("FAIL mid_cos_addr: got %0d expected 1", cos_addr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.out_sat} !== 3'b100 || bus.d_out !== 40'd0 || bus.a_out !== 64'd0) begin
            n_bad++;
            $display("FAIL mid_reset_out: got rdy/vld/sat=%b a=%0d d=%0d expected 100 0 0",
                     {bus.in_ready, bus.out_valid, bus.out_sat}, bus.a_out, bus.d_out);
        end
        tick();
        n_cmp++;
        if (cos_addr !== 7'd0) begin
            n_bad++;
            $display("FAIL mid_reset_addr: got %0d expected 0", cos_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_clear();
        int hits;
        int lat_cyc;
        asin_mode = 0;
        send_fix(24'h10, 24'h2000);
        repeat (3) tick();
        asin_mode = 2;
        send_fix(24'h10, 24'h2001);
        repeat (10) tick();
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.lat_in   = 24'h55;
        bus.lon_in   = 24'h66;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ready: got rdy=%0b vld=%0b expected 0 0", bus.in_ready, bus.out_valid);
        end
        tick();
        n_cmp++;
        if (cos_addr !== 7'd0 || asin_addr !== 6'd0) begin
            n_bad++;
            $display("FAIL clear_no_accept: got cos=%0d asin=%0d expected 0 0", cos_addr, asin_addr);
        end
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_release_ready: got %0b expected 1", bus.in_ready);
        end
        watch_quiet(80, hits);
        n_cmp++;
        if (hits !== 0) begin
            n_bad++;
            $display("FAIL clear_no_out: got %0d strobes expected 0", hits);
        end
        asin_mode = 0;
        send_fix(24'h10, 24'h3000);
        watch_quiet(10, hits);
        n_cmp++;
        if (hits !== 0) begin
            n_bad++;
            $display("FAIL clear_first_again: got %0d strobes expected 0", hits);
        end
        send_fix(24'h10, 24'h3001);
        wait_out(30, lat_cyc);
        n_cmp++;
        if (lat_cyc !== 6 || bus.a_out !== 64'd45849 || bus.d_out !== 40'd136) begin
            n_bad++;
            $display("FAIL clear_resume: got lat=%0d a=%0d d=%0d expected 6 45849 136",
                     lat_cyc, bus.a_out, bus.d_out);
        end
    endtask

    initial begin
        test_reset();
        test_first_fix();
        test_second_fix();
        test_identical();
        test_saturate();
        test_reset_mid_scan();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpsdc_track.md
Name: gpsdc_track

Overview:
- Parametrised great-circle distance engine for a stream of GPS fixes, using the haversine formula.
- Accepts fixes over a valid/ready handshake and caches the previous fix and its interpolated cosine.
- Per new fix, linearly scans an external cosine ROM and then an external arcsine ROM, with linear interpolation, and emits the distance from the previous fix.
- Sits between the GPS front-end and the track-logging datapath; handles table-edge saturation and mid-stream clear.

Parameters:
- COORD_W, 24, lat/lon width (unsigned raw units)
- COS_AW, 7, cosine ROM address width (depth 2^COS_AW)
- COS_YW, 48, cosine value width, unsigned Q0.COS_YW; cosine x field is COORD_W+16
- ASIN_AW, 6, arcsine ROM address width
- A_W, 64, haversine term "a" width; also the arcsine x field width
- ASIN_YW, 64, arcsine y field width
- K_RAD, 16'h477, degree-to-radian scale constant
- R_EARTH, 12756274, Earth diameter constant
- D_SHIFT, 32, right shift applied to R_EARTH*y
- D_W, 40, distance width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  drop stored fix, abort current work
- in_valid  in  1  fix offered
- in_ready  out  1  high only in IDLE and only while clear=0
- lat_in  in  COORD_W  latitude
- lon_in  in  COORD_W  longitude
- cos_addr  out  COS_AW  registered cosine ROM address
- cos_data  in  COORD_W+16+COS_YW  {x,y}, combinational ROM, valid in the same cycle as the address
- asin_addr  out  ASIN_AW  registered arcsine ROM address
- asin_data  in  2*... {x[A_W], y[ASIN_YW]}, combinational ROM
- out_valid  out  1  one-cycle result strobe
- a_out  out  A_W  haversine term
- d_out  out  D_W  distance
- out_sat  out  1  a table scan saturated for this result

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State is IDLE, no stored fix.
- States: IDLE -> COS_SCAN -> COS_DONE -> (IDLE | ASIN_SCAN) -> OUT -> IDLE.
- IDLE:
  - Accept a fix on in_valid&in_ready.
  - Latch lat/lon, set cos_addr=0, go to COS_SCAN.
- Scan rule (both tables), one address per cycle:
  - Query for cosine: qx={lat,16'h0}. Query for arcsine: qx=a.
  - If entry.x > qx: stop.
  - Otherwise save the entry as "prev" and increment the address.
- Interpolation:
  - At addr 0 hit: y = entry0.y, with no previous entry.
  - Otherwise: y = (y0*(x1-x0) + (qx-x0)*(y1-y0)) / (x1-x0). The numerator is exact and signed; the division truncates.
  - Scan reaching the last address without a hit: y = last.y and the sat flag is set.
- COS_DONE:
  - Latch c_new.
  - If no stored fix: store the fix and c_new, return to IDLE, no output.
  - Else compute a, set asin_addr=0, go to ASIN_SCAN.
- Arithmetic (all unsigned, full-width intermediates, no truncation before the final shift):
  - dlat = |lat1-lat0|; dlon likewise.
  - s = (d*K_RAD)>>1.
  - a = (s_lat²·2^(2·COS_YW) + c_old·c_new·s_lon²) >> (2·COS_YW), truncated to A_W.
- OUT:
  - Register a_out, d_out = (R_EARTH*y)>>D_SHIFT, and out_sat. out_sat is the OR of both scans.
  - Pulse out_valid for 1 cycle.
  - Shift the new fix and c_new into the previous-fix slot. Return to IDLE.
- Latency: accept to out_valid = (cos hit index+1) + 1 + (asin hit index+1) + 1 cycles.
- Output holding: a_out, d_out and out_sat hold between strobes.
- clear:
  - Synchronous, any state: go to IDLE, invalidate the stored fix, no out_valid.
  - clear together with in_valid: clear wins and the fix is not accepted.
- reset_n low mid-scan: immediate return to reset values.

Optional Feature:
- Macro GPSDC_TRACK_ACCUM_EN.
- When defined:
  - Adds output total_d [D_W+8].
  - total_d accumulates d_out on each out_valid, saturating at all-ones.
  - Zeroed by reset and clear; updates in the same cycle as out_valid.
- When undefined: the port is absent and the behaviour is otherwise identical.

Decomposition:
- Package gpsdc_pkg: state enum, default constants K_RAD and R_EARTH, width-helper localparams.
- Sub-module gpsdc_lut_interp: scan address counter, prev-entry register, hit/saturation detection and interpolation divider.
  - Parametrised by AW, XW and YW.
  - Instantiated twice: cosine and arcsine.

Test Plan:
- Reset mid-COS_SCAN -> outputs 0, in_ready=1, cos_addr=0 next cycle.
- First fix after reset, lat=0x10 -> no out_valid, back in IDLE after 3 cycles. Cosine table used here and below: e0={0,2^47}, e1={0x200000,2^46}.
- Second fix, same lat, dlon=1 (cosine as above):
  - c=3·2^45 for both fixes.
  - asin table identity-shaped with e0.x=0 -> a_out=45849.
  - out_valid exactly 1 cycle.
- Identical consecutive fixes, asin table e0={0,0}, e1={100,100} -> a_out=0, d_out=0, out_sat=0.
- a exceeding every asin x (all x=0) -> out_sat=1, d_out=(R_EARTH·y_last)>>32.
- clear asserted in ASIN_SCAN with in_valid high -> no out_valid, fix not accepted. The next fix produces no output; it is treated as a first fix.
